srl_fifo_ctrl: RTL and testbench

SRL_FIFO_CTRL -- requirements
Module: srl_fifo_ctrl

---
 rtl/srl_fifo_ctrl.sv | 82 ++++++++
 tb/tb_srl_fifo_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/srl_fifo_ctrl.sv
// Control for a SRLC32E-based FIFO with a registered output stage.
// Tracks SRL occupancy, drives shift/tap/load enables and status flags.
module srl_fifo_ctrl #(
    parameter int DEPTH       = 32,
    parameter int AFULL_LEVEL = 28
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       FLUSH,
    input  logic       S_VALID,
    output logic       S_READY,
    output logic       M_VALID,
    input  logic       M_READY,
    output logic       SRL_CE,
    output logic [4:0] SRL_A,
    output logic       OREG_CE,
    output logic [5:0] COUNT,
    output logic       FULL,
    output logic       EMPTY,
    output logic       AFULL
);

    localparam logic [0:0] OUT_EMPTY = 1'b0;
    localparam logic [0:0] OUT_VALID = 1'b1;

    logic [5:0] srl_cnt_q, srl_cnt_d;
    logic [0:0] out_state_q, out_state_d;
    logic [5:0] count_q, count_d;
    logic       push;
    logic       load;
    logic       srl_nz;

    assign srl_nz  = (srl_cnt_q != 6'd0);
    assign S_READY = (srl_cnt_q < 6'(DEPTH)) && !RST && !FLUSH;
    assign push    = S_VALID && S_READY;
    assign load    = srl_nz && !RST && !FLUSH
                     && ((out_state_q == OUT_EMPTY) || M_READY);

    assign SRL_CE  = push;
    assign OREG_CE = load;
    // Tap selects the oldest entry as it sits before this edge's shift.
    assign SRL_A   = srl_nz ? 5'(srl_cnt_q - 6'd1) : 5'd0;

    assign M_VALID = (out_state_q == OUT_VALID);
    assign COUNT   = count_q;
    assign EMPTY   = (count_q == 6'd0);
    assign FULL    = (srl_cnt_q == 6'(DEPTH));
    assign AFULL   = (count_q >= 6'(AFULL_LEVEL));

    always_comb begin
        srl_cnt_d   = srl_cnt_q;
        out_state_d = out_state_q;
        unique case ({push, load})
            2'b10:   srl_cnt_d = srl_cnt_q + 6'd1;
            2'b01:   srl_cnt_d = srl_cnt_q - 6'd1;
            default: srl_cnt_d = srl_cnt_q;
        endcase
        unique case (out_state_q)
            OUT_EMPTY: if (load) out_state_d = OUT_VALID;
            OUT_VALID: if (M_READY && !load) out_state_d = OUT_EMPTY;
            default:   out_state_d = OUT_EMPTY;
        endcase
        if (RST || FLUSH) begin
            srl_cnt_d   = 6'd0;
            out_state_d = OUT_EMPTY;
        end
        count_d = srl_cnt_d + {5'd0, out_state_d};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            srl_cnt_q   <= 6'd0;
            out_state_q <= OUT_EMPTY;
            count_q     <= 6'd0;
        end else begin
            srl_cnt_q   <= srl_cnt_d;
            out_state_q <= out_state_d;
            count_q     <= count_d;
        end
    end

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// Bench for srl_fifo_ctrl: behavioural SRL slices and output register
// around the controller, directed vectors plus a queue scoreboard.
module tb_srl_fifo_ctrl;

    logic       CLK;
    logic       RST;
    logic       FLUSH;
    logic       S_VALID;
    logic       S_READY;
    logic       M_VALID;
    logic       M_READY;
    logic       SRL_CE;
    logic [4:0] SRL_A;
    logic       OREG_CE;
    logic [5:0] COUNT;
    logic       FULL;
    logic       EMPTY;
    logic       AFULL;

    logic [7:0] din;
    logic [7:0] srl [32];
    logic [7:0] oreg;
    logic [7:0] q [$];
    int         n_vec;
    int         n_err;

    srl_fifo_ctrl #(.DEPTH(32), .AFULL_LEVEL(28)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .FLUSH   (FLUSH),
        .S_VALID (S_VALID),
        .S_READY (S_READY),
        .M_VALID (M_VALID),
        .M_READY (M_READY),
        .SRL_CE  (SRL_CE),
        .SRL_A   (SRL_A),
        .OREG_CE (OREG_CE),
        .COUNT   (COUNT),
        .FULL    (FULL),
        .EMPTY   (EMPTY),
        .AFULL   (AFULL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // External datapath: 8 SRLC32E-style slices and the output register.
    always @(posedge CLK) begin
        if (SRL_CE) begin
            for (int i = 31; i > 0; i--) srl[i] <= srl[i-1];
            srl[0] <= din;
        end
        if (OREG_CE) oreg <= srl[SRL_A];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic set(input logic rst, input logic fl, input logic sv,
                       input logic [7:0] d, input logic mr);
        RST = rst;
        FLUSH = fl;
        S_VALID = sv;
        din = d;
        M_READY = mr;
        #1;
    endtask

    task automatic adv();
        logic [7:0] e;
        if (!RST && !FLUSH && M_VALID && M_READY) begin
            if (q.size() == 0) begin
                chk("pop_underflow", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("pop_data", {24'd0, oreg}, {24'd0, e});
            end
        end
        if (S_VALID && S_READY) q.push_back(din);
        if (RST || FLUSH) q.delete();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        set(1, 0, 0, 8'h00, 0);
        @(posedge CLK);
        #1;

        // Reset dominates live traffic.
        set(1, 1, 1, 8'h11, 1);
        chk("rst_s_ready", S_READY, 0);
        chk("rst_srl_ce", SRL_CE, 0);
        chk("rst_oreg_ce", OREG_CE, 0);
        adv();
        set(0, 0, 0, 8'h00, 0);
        chk("rst_m_valid", M_VALID, 0);
        chk("rst_count", COUNT, 0);
        chk("rst_empty", EMPTY, 1);
        chk("rst_full", FULL, 0);
        chk("rst_afull", AFULL, 0);
        chk("rst_srl_a", SRL_A, 0);
        chk("rst_s_ready_rel", S_READY, 1);

        // Single write, two-cycle latency.
        set(0, 0, 1, 8'hA5, 0);
        chk("w1_srl_ce", SRL_CE, 1);
        chk("w1_oreg_ce", OREG_CE, 0);
        adv();
        set(0, 0, 0, 8'h00, 0);
        chk("w2_oreg_ce", OREG_CE, 1);
        chk("w2_srl_a", SRL_A, 0);
        chk("w2_m_valid", M_VALID, 0);
        adv();
        chk("w3_m_valid", M_VALID, 1);
        chk("w3_data", oreg, 8'hA5);
        chk("w3_count", COUNT, 1);
        set(0, 0, 0, 8'h00, 1);
        adv();
        chk("w4_m_valid", M_VALID, 0);
        chk("w4_empty", EMPTY, 1);

        // Fill with consumer stalled.
        for (int i = 0; i < 33; i++) begin
            set(0, 0, 1, 8'(i + 1), 0);
            adv();
        end
        set(0, 0, 1, 8'hEE, 0);
        chk("fill_count", COUNT, 33);
        chk("fill_full", FULL, 1);
        chk("fill_afull", AFULL, 1);
        chk("fill_s_ready", S_READY, 0);
        chk("fill_srl_a", SRL_A, 31);
        chk("fill_34_srl_ce", SRL_CE, 0);
        adv();
        chk("fill_34_count", COUNT, 33);

        // Drain: no ready-through at full, ready returns next cycle.
        set(0, 0, 0, 8'h00, 1);
        chk("drain_no_rt", S_READY, 0);
        adv();
        chk("drain_rdy_back", S_READY, 1);
        for (int i = 1; i < 33; i++) begin
            chk("drain_m_valid", M_VALID, 1);
            chk("drain_afull", AFULL, (33 - i) >= 28);
            adv();
        end
        chk("drain_empty", EMPTY, 1);
        chk("drain_count", COUNT, 0);
        chk("drain_m_valid_end", M_VALID, 0);

        // Streaming at COUNT=5.
        for (int i = 0; i < 5; i++) begin
            set(0, 0, 1, 8'(8'h40 + i), 0);
            adv();
        end
        chk("strm_count0", COUNT, 5);
        for (int i = 0; i < 100; i++) begin
            set(0, 0, 1, 8'(8'h80 + i), 1);
            adv();
            chk("strm_count", COUNT, 5);
            chk("strm_srl_a", SRL_A, 3);
        end
        set(0, 0, 0, 8'h00, 1);
        for (int i = 0; i < 6; i++) adv();
        chk("strm_empty", EMPTY, 1);

        // Flush at COUNT=10 with push and pop requested.
        for (int i = 0; i < 10; i++) begin
            set(0, 0, 1, 8'(8'h20 + i), 0);
            adv();
        end
        chk("fl_count0", COUNT, 10);
        set(0, 1, 1, 8'h55, 1);
        chk("fl_srl_ce", SRL_CE, 0);
        chk("fl_oreg_ce", OREG_CE, 0);
        chk("fl_s_ready", S_READY, 0);
        adv();
        set(0, 0, 1, 8'h77, 0);
        chk("fl_count", COUNT, 0);
        chk("fl_m_valid", M_VALID, 0);
        adv();
        set(0, 0, 0, 8'h00, 0);
        adv();
        chk("fl_new_valid", M_VALID, 1);
        chk("fl_new_data", oreg, 8'h77);
        set(0, 0, 0, 8'h00, 1);
        adv();

        // Reset together with flush mid-transfer.
        for (int i = 0; i < 10; i++) begin
            set(0, 0, 1, 8'(8'h60 + i), 0);
            adv();
        end
        set(1, 1, 1, 8'h99, 1);
        chk("rf_srl_ce", SRL_CE, 0);
        chk("rf_oreg_ce", OREG_CE, 0);
        adv();
        set(0, 0, 0, 8'h00, 1);
        chk("rf_count", COUNT, 0);
        chk("rf_m_valid", M_VALID, 0);
        adv();
        chk("rf_m_valid_next", M_VALID, 0);

        // Random traffic against the queue model.
        for (int i = 0; i < 10000; i++) begin
            set(0, 0, 1'($urandom % 2), 8'($urandom),
                1'(($urandom % 3) != 0));
            adv();
            chk("rnd_count", COUNT, 32'(q.size()));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
